// File: rtl/axi_image_in.sv
// axi_image_in
//   AXI4-Lite write-only responder (AW/W/B) that lets the host load one image
//   into a local pixel buffer, then streams that buffer to the SNN core after
//   a CTRL write requests START.
//
//   Address window (byte offsets from ADDR_BASE):
//     0x000..0x0FF  pixel words, 4 pixels per word, little-endian byte lanes
//     0x100..0x103  CTRL, bit0 = START (write-only, self-clearing)
//     anything else -> SLVERR, no state change
//
//   Optional build macro: AXI_IMAGE_IN_ZERO_SKIP_EN
//     When defined, zero-valued pixels are scanned past instead of presented.
//     PIX_ADDR still carries the true pixel index.
//
//   Ports:
//     ACLK, ARESET            clock / synchronous active-high reset
//     AWADDR/AWPROT/AWVALID/AWREADY   write address channel (AWPROT ignored)
//     WDATA/WSTRB/WVALID/WREADY       write data channel
//     BRESP/BVALID/BREADY             write response channel
//     PIX_DATA/PIX_ADDR/PIX_VALID/PIX_READY  pixel stream to the core
//     IMAGE_DONE              1-cycle pulse after the last pixel is accepted
//     BUSY                    high while the stream is running
`timescale 1ns/1ps

module axi_image_in #(
   parameter logic [31:0] ADDR_BASE  = 32'h4000_1000,
   parameter int unsigned NUM_PIXELS = 256,
   parameter int unsigned PIX_W      = 8
) (
   input  logic             ACLK,
   input  logic             ARESET,
   input  logic [31:0]      AWADDR,
   input  logic [2:0]       AWPROT,
   input  logic             AWVALID,
   output logic             AWREADY,
   input  logic [31:0]      WDATA,
   input  logic [3:0]       WSTRB,
   input  logic             WVALID,
   output logic             WREADY,
   output logic [1:0]       BRESP,
   output logic             BVALID,
   input  logic             BREADY,
   output logic [PIX_W-1:0] PIX_DATA,
   output logic [7:0]       PIX_ADDR,
   output logic             PIX_VALID,
   input  logic             PIX_READY,
   output logic             IMAGE_DONE,
   output logic             BUSY
);

   localparam logic [8:0] NUM_WORDS = 9'(NUM_PIXELS / 4);
   localparam logic [7:0] LAST_IDX  = 8'(NUM_PIXELS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_STREAM,
      S_SCAN
   } state_t;

   state_t           state;
   logic [PIX_W-1:0] mem [NUM_PIXELS];

   // AXI holding registers
   logic             aw_held;
   logic             w_held;
   logic [31:0]      aw_addr_q;
   logic [31:0]      w_data_q;
   logic [3:0]       w_strb_q;

   // Decode of the held write
   logic [31:0]      off;
   logic [5:0]       word_idx;
   logic             is_pix;
   logic             is_ctrl;
   logic             commit;
   logic             pix_wr;
   logic             start_req;
   logic             wr_err;

   logic [7:0]       idx;
   logic [7:0]       nxt_idx;

   logic             unused;

   assign unused  = ^{AWPROT, off[1:0]};

   assign AWREADY = !aw_held && !BVALID;
   assign WREADY  = !w_held && !BVALID;

   always_comb begin
      off       = aw_addr_q - ADDR_BASE;
      word_idx  = off[7:2];
      is_pix    = (off[31:8] == '0) && ({3'b000, word_idx} < NUM_WORDS);
      is_ctrl   = (off[31:2] == 30'h40);
      commit    = aw_held && w_held;
      pix_wr    = commit && is_pix && !BUSY;
      start_req = commit && is_ctrl && w_data_q[0] && w_strb_q[0];
      // CTRL is always OKAY (START while busy is simply ignored); pixel
      // writes are only accepted while the stream is idle.
      wr_err    = !(is_ctrl || (is_pix && !BUSY));
      nxt_idx   = idx + 8'd1;
   end

   // AXI channels, commit and pixel buffer
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         BVALID    <= 1'b0;
         BRESP     <= 2'b00;
         for (int unsigned i = 0; i < NUM_PIXELS; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (AWVALID && AWREADY) begin
            aw_held   <= 1'b1;
            aw_addr_q <= AWADDR;
         end
         if (WVALID && WREADY) begin
            w_held   <= 1'b1;
            w_data_q <= WDATA;
            w_strb_q <= WSTRB;
         end
         // Commit and B handshake are mutually exclusive: the holds cannot
         // fill while BVALID is high.
         if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            BVALID  <= 1'b1;
            BRESP   <= wr_err ? 2'b10 : 2'b00;
            if (pix_wr) begin
               for (int unsigned i = 0; i < 4; i++) begin
                  if (w_strb_q[i]) begin
                     mem[{word_idx, 2'(i)}] <= w_data_q[PIX_W*i +: PIX_W];
                  end
               end
            end
         end else if (BVALID && BREADY) begin
            BVALID <= 1'b0;
         end
      end
   end

   // Pixel stream FSM; all stream outputs are registered
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state      <= S_IDLE;
         idx        <= '0;
         PIX_DATA   <= '0;
         PIX_ADDR   <= '0;
         PIX_VALID  <= 1'b0;
         IMAGE_DONE <= 1'b0;
         BUSY       <= 1'b0;
      end else begin
         IMAGE_DONE <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_req) begin
                  idx      <= '0;
                  PIX_ADDR <= '0;
                  PIX_DATA <= mem[0];
                  BUSY     <= 1'b1;
`ifdef AXI_IMAGE_IN_ZERO_SKIP_EN
                  if (mem[0] != '0) begin
                     PIX_VALID <= 1'b1;
                     state     <= S_STREAM;
                  end else begin
                     state     <= S_SCAN;
                  end
`else
                  PIX_VALID <= 1'b1;
                  state     <= S_STREAM;
`endif
               end
            end

            S_STREAM: begin
               if (PIX_READY) begin
                  if (idx == LAST_IDX) begin
                     PIX_VALID  <= 1'b0;
                     BUSY       <= 1'b0;
                     IMAGE_DONE <= 1'b1;
                     state      <= S_IDLE;
                  end else begin
                     // Look ahead one pixel so back-to-back accepts have no bubble
                     idx      <= nxt_idx;
                     PIX_ADDR <= nxt_idx;
                     PIX_DATA <= mem[nxt_idx];
`ifdef AXI_IMAGE_IN_ZERO_SKIP_EN
                     if (mem[nxt_idx] == '0) begin
                        PIX_VALID <= 1'b0;
                        state     <= S_SCAN;
                     end
`endif
                  end
               end
            end

`ifdef AXI_IMAGE_IN_ZERO_SKIP_EN
            // idx points at a known-zero pixel; step one pixel per cycle
            S_SCAN: begin
               if (idx == LAST_IDX) begin
                  BUSY       <= 1'b0;
                  IMAGE_DONE <= 1'b1;
                  state      <= S_IDLE;
               end else begin
                  idx      <= nxt_idx;
                  PIX_ADDR <= nxt_idx;
                  PIX_DATA <= mem[nxt_idx];
                  if (mem[nxt_idx] != '0) begin
                     PIX_VALID <= 1'b1;
                     state     <= S_STREAM;
                  end
               end
            end
`endif

            default: begin
               state     <= S_IDLE;
               PIX_VALID <= 1'b0;
               BUSY      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_image_in.sv
// Directed testbench for axi_image_in. Expected values are hand-computed and
// held in a bench-side image array that mirrors what the host has written.
`timescale 1ns/1ps

module tb_axi_image_in;

   localparam int NPIX = 256;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic [31:0] AWADDR;
   logic [2:0]  AWPROT;
   logic        AWVALID;
   logic        AWREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WVALID;
   logic        WREADY;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY;
   logic [7:0]  PIX_DATA;
   logic [7:0]  PIX_ADDR;
   logic        PIX_VALID;
   logic        PIX_READY;
   logic        IMAGE_DONE;
   logic        BUSY;

   int checks = 0;
   int errors = 0;

   logic [7:0] img [NPIX];

   axi_image_in #(
      .ADDR_BASE (32'h4000_1000),
      .NUM_PIXELS(256),
      .PIX_W     (8)
   ) dut (
      .ACLK      (ACLK),
      .ARESET    (ARESET),
      .AWADDR    (AWADDR),
      .AWPROT    (AWPROT),
      .AWVALID   (AWVALID),
      .AWREADY   (AWREADY),
      .WDATA     (WDATA),
      .WSTRB     (WSTRB),
      .WVALID    (WVALID),
      .WREADY    (WREADY),
      .BRESP     (BRESP),
      .BVALID    (BVALID),
      .BREADY    (BREADY),
      .PIX_DATA  (PIX_DATA),
      .PIX_ADDR  (PIX_ADDR),
      .PIX_VALID (PIX_VALID),
      .PIX_READY (PIX_READY),
      .IMAGE_DONE(IMAGE_DONE),
      .BUSY      (BUSY)
   );

   always #5 ACLK = ~ACLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_beats();
      int c;
      c = 0;
      for (int i = 0; i < NPIX; i++) begin
`ifdef AXI_IMAGE_IN_ZERO_SKIP_EN
         if (img[i] != 8'h00) c++;
`else
         c++;
`endif
      end
      return c;
   endfunction

   // Called just after a rising edge; returns just after a rising edge.
   task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int w_lead, input int b_delay,
                            input logic [1:0] exp_resp, input string tag);
      bit aw_done, w_done, aw_hs, w_hs;
      int n;
      aw_done = 0; w_done = 0; n = 0;
      AWADDR = a; WDATA = d; WSTRB = s; WVALID = 1'b1; BREADY = 1'b0;
      while (!(aw_done && w_done) && n < 50) begin
         AWVALID = !aw_done && (n >= w_lead);
         @(negedge ACLK);
         aw_hs = AWVALID && AWREADY;
         w_hs  = WVALID && WREADY;
         @(posedge ACLK); #1;
         if (aw_hs) begin aw_done = 1; AWVALID = 1'b0; end
         if (w_hs)  begin w_done  = 1; WVALID  = 1'b0; end
         n++;
      end
      AWVALID = 1'b0; WVALID = 1'b0;
      chk({tag, "_hs_done"}, 32'(aw_done && w_done), 1);
      n = 0;
      @(negedge ACLK);
      while (!BVALID && n < 20) begin @(negedge ACLK); n++; end
      chk({tag, "_bvalid"}, 32'(BVALID), 1);
      repeat (b_delay) begin
         chk({tag, "_stall_bvalid"}, 32'(BVALID), 1);
         chk({tag, "_stall_bresp"}, 32'(BRESP), 32'(exp_resp));
         chk({tag, "_stall_awready"}, 32'(AWREADY), 0);
         @(negedge ACLK);
      end
      chk({tag, "_bresp"}, 32'(BRESP), 32'(exp_resp));
      BREADY = 1'b1;
      @(posedge ACLK); #1;
      BREADY = 1'b0;
      @(negedge ACLK);
      chk({tag, "_bvalid_clr"}, 32'(BVALID), 0);
      chk({tag, "_awready_back"}, 32'(AWREADY), 1);
      @(posedge ACLK); #1;
   endtask

   // Receives one full image pass. toggle=1 drives PIX_READY 1,0,1,...
   task automatic stream_rx(input bit toggle, input string tag, output int beats, output int done_cyc);
      int pos, dones, cyc;
      bit rdy, fin;
      pos = 0; dones = 0; cyc = 0; rdy = 1; fin = 0;
      beats = 0; done_cyc = -1;
      while (!fin && cyc < 2000) begin
         PIX_READY = rdy;
         @(negedge ACLK);
`ifdef AXI_IMAGE_IN_ZERO_SKIP_EN
         while (pos < NPIX && img[pos] == 8'h00) pos++;
`endif
         if (PIX_VALID) begin
            chk({tag, "_addr"}, 32'(PIX_ADDR), 32'(pos));
            chk({tag, "_data"}, 32'(PIX_DATA), (pos < NPIX) ? 32'(img[pos]) : 32'hFFFF_FFFF);
            chk({tag, "_busy"}, 32'(BUSY), 1);
            if (PIX_READY) begin pos++; beats++; end
         end
         if (IMAGE_DONE) begin
            dones++;
            fin = 1;
            done_cyc = cyc;
            chk({tag, "_done_pos"}, 32'(pos), NPIX);
            chk({tag, "_done_busy"}, 32'(BUSY), 0);
            chk({tag, "_done_valid"}, 32'(PIX_VALID), 0);
         end
         cyc++;
         @(posedge ACLK); #1;
         if (toggle) rdy = !rdy;
      end
      chk({tag, "_finished"}, 32'(fin), 1);
      PIX_READY = 1'b0;
      repeat (4) begin
         @(negedge ACLK);
         if (IMAGE_DONE) dones++;
      end
      chk({tag, "_done_pulses"}, 32'(dones), 1);
      @(posedge ACLK); #1;
   endtask

   initial begin
      int beats, dcyc, n, late_done;

      for (int i = 0; i < NPIX; i++) img[i] = 8'h00;
      ARESET = 1'b1; AWADDR = '0; AWPROT = '0; AWVALID = 1'b0;
      WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0; PIX_READY = 1'b0;

      // Reset state
      repeat (2) @(posedge ACLK);
      #1 ARESET = 1'b0;
      @(negedge ACLK);
      chk("rst_awready", 32'(AWREADY), 1);
      chk("rst_wready", 32'(WREADY), 1);
      chk("rst_bvalid", 32'(BVALID), 0);
      chk("rst_bresp", 32'(BRESP), 0);
      chk("rst_pix_valid", 32'(PIX_VALID), 0);
      chk("rst_busy", 32'(BUSY), 0);
      chk("rst_done", 32'(IMAGE_DONE), 0);
      chk("rst_pix_addr", 32'(PIX_ADDR), 0);
      chk("rst_pix_data", 32'(PIX_DATA), 0);
      @(posedge ACLK); #1;

      // Simultaneous AW/W at edge N -> BVALID at N+1
      AWADDR = 32'h4000_1004; AWVALID = 1'b1;
      WDATA = 32'h4433_2211; WSTRB = 4'hF; WVALID = 1'b1;
      @(negedge ACLK);
      chk("lat_awready_pre", 32'(AWREADY), 1);
      chk("lat_wready_pre", 32'(WREADY), 1);
      @(posedge ACLK); #1;
      AWVALID = 1'b0; WVALID = 1'b0;
      @(negedge ACLK);
      chk("lat_bvalid_n", 32'(BVALID), 0);
      chk("lat_awready_held", 32'(AWREADY), 0);
      @(posedge ACLK); #1;
      @(negedge ACLK);
      chk("lat_bvalid_n1", 32'(BVALID), 1);
      chk("lat_bresp", 32'(BRESP), 0);
      chk("lat_wready_b", 32'(WREADY), 0);
      BREADY = 1'b1;
      @(posedge ACLK); #1;
      BREADY = 1'b0;
      @(negedge ACLK);
      chk("lat_bvalid_clr", 32'(BVALID), 0);
      chk("lat_awready_back", 32'(AWREADY), 1);
      @(posedge ACLK); #1;
      img[4] = 8'h11; img[5] = 8'h22; img[6] = 8'h33; img[7] = 8'h44;

      // W three cycles ahead of AW, partial strobes
      axi_write(32'h4000_1000, 32'hAABB_CCDD, 4'b0101, 3, 0, 2'b00, "w_first");
      img[0] = 8'hDD; img[2] = 8'hBB;

      // Last word, BREADY held low 5 cycles
      axi_write(32'h4000_10FC, 32'hFFEE_0001, 4'hF, 0, 5, 2'b00, "bstall");
      img[252] = 8'h01; img[253] = 8'h00; img[254] = 8'hEE; img[255] = 8'hFF;

      // Decode errors and a CTRL write without START
      axi_write(32'h4000_1200, 32'h0000_0001, 4'hF, 0, 0, 2'b10, "err_1200");
      axi_write(32'h4000_0FFC, 32'h0000_0001, 4'hF, 0, 0, 2'b10, "err_below");
      axi_write(32'h4000_1104, 32'h0000_0001, 4'hF, 0, 0, 2'b10, "err_1104");
      axi_write(32'h4000_1100, 32'h0000_0000, 4'hF, 0, 0, 2'b00, "ctrl_nostart");
      axi_write(32'h4000_1100, 32'h0000_0001, 4'b1110, 0, 0, 2'b00, "ctrl_nostrb");
      @(negedge ACLK);
      chk("nostart_busy", 32'(BUSY), 0);
      chk("nostart_valid", 32'(PIX_VALID), 0);
      @(posedge ACLK); #1;

      // START, toggling PIX_READY; rejected pixel write and ignored START meanwhile
      axi_write(32'h4000_1100, 32'h0000_0001, 4'h1, 0, 0, 2'b00, "start1");
      @(negedge ACLK);
      chk("start1_busy", 32'(BUSY), 1);
`ifndef AXI_IMAGE_IN_ZERO_SKIP_EN
      chk("start1_valid", 32'(PIX_VALID), 1);
      chk("start1_addr", 32'(PIX_ADDR), 0);
`endif
      @(posedge ACLK); #1;
      fork
         stream_rx(1'b1, "strm1", beats, dcyc);
         begin
            repeat (10) @(posedge ACLK);
            #1;
            axi_write(32'h4000_1000, 32'h1234_5678, 4'hF, 0, 0, 2'b10, "busy_wr");
            axi_write(32'h4000_1100, 32'h0000_0001, 4'h1, 0, 0, 2'b00, "busy_start");
         end
      join
      chk("strm1_beats", 32'(beats), 32'(exp_beats()));

      // Re-START resends the same image; always ready -> no bubbles
      axi_write(32'h4000_1100, 32'h0000_0001, 4'h1, 0, 0, 2'b00, "start2");
      stream_rx(1'b0, "strm2", beats, dcyc);
      chk("strm2_beats", 32'(beats), 32'(exp_beats()));
`ifndef AXI_IMAGE_IN_ZERO_SKIP_EN
      chk("strm2_done_cycle", 32'(dcyc), 256);
`endif

      // Reset mid-stream
      axi_write(32'h4000_1100, 32'h0000_0001, 4'h1, 0, 0, 2'b00, "start3");
      PIX_READY = 1'b1; n = 0;
      @(negedge ACLK);
      while (!(PIX_VALID && PIX_ADDR >= 8'd100) && n < 1000) begin
         @(negedge ACLK);
         n++;
      end
      chk("mid_reached", 32'(PIX_VALID && PIX_ADDR >= 8'd100), 1);
      ARESET = 1'b1;
      @(posedge ACLK); #1;
      ARESET = 1'b0;
      @(negedge ACLK);
      chk("mid_rst_valid", 32'(PIX_VALID), 0);
      chk("mid_rst_busy", 32'(BUSY), 0);
      chk("mid_rst_done", 32'(IMAGE_DONE), 0);
      late_done = 0;
      repeat (5) begin
         @(negedge ACLK);
         if (IMAGE_DONE) late_done++;
      end
      chk("mid_rst_no_done", 32'(late_done), 0);
      @(posedge ACLK); #1;
      PIX_READY = 1'b0;
      for (int i = 0; i < NPIX; i++) img[i] = 8'h00;

      // Buffer cleared by reset: all-zero pass
      axi_write(32'h4000_1100, 32'h0000_0001, 4'h1, 0, 0, 2'b00, "start4");
      stream_rx(1'b0, "strm_zero", beats, dcyc);
      chk("strm_zero_beats", 32'(beats), 32'(exp_beats()));

      // Sparse image: only pixels 3 and 200 nonzero
      axi_write(32'h4000_1000, 32'h0700_0000, 4'b1000, 0, 0, 2'b00, "sparse_p3");
      axi_write(32'h4000_10C8, 32'h0000_00C8, 4'b0001, 0, 0, 2'b00, "sparse_p200");
      img[3] = 8'h07; img[200] = 8'hC8;
      axi_write(32'h4000_1100, 32'h0000_0001, 4'h1, 0, 0, 2'b00, "start5");
      stream_rx(1'b0, "strm_sparse", beats, dcyc);
      chk("strm_sparse_beats", 32'(beats), 32'(exp_beats()));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
